// File: rtl/core_mem_arbiter.sv
// Two-port arbiter sharing one single-ported data memory (port 0 = core, port 1 = loader/debug).
// Build option: define ARB_RR_EN for round-robin priority; otherwise port 0 always wins.
module core_mem_arbiter #(
  parameter int              AW       = 32,
  parameter int              DW       = 32,
  parameter int              TIMEOUT  = 16,
  parameter logic [DW-1:0]   ERR_DATA = 32'hDEADBEEF
) (
  input  logic          clk,
  input  logic          reset,

  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_err,

  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_err,

  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,

  output logic          busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_e          state_q;
  logic            owner_q;
  logic [7:0]      cnt_q;
  logic [7:0]      cnt_d;
  logic            mem_req_q;
  logic            mem_we_q;
  logic [AW-1:0]   mem_addr_q;
  logic [DW-1:0]   mem_wdata_q;
  logic [1:0]      gnt_q;
  logic [1:0]      rvalid_q;
  logic [1:0]      err_q;
  logic [DW-1:0]   rdata_q [2];
  logic            busy_q;

  logic [1:0]      req_eff;
  logic            win_d;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;

  // A requester still holds req during its gnt cycle; only a req held past it is a new request.
  assign req_eff = {m1_req & ~gnt_q[1], m0_req & ~gnt_q[0]};

`ifdef ARB_RR_EN
  logic last_gnt_q;

  // Reset value 1 means "port 1 was last served", so port 0 has priority out of reset.
  always_comb begin
    win_d = 1'b0;
    if (req_eff[0] && req_eff[1]) begin
      win_d = ~last_gnt_q;
    end else if (req_eff[1]) begin
      win_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_gnt_q <= 1'b1;
    end else if (state_q == S_ISSUE && mem_ack) begin
      last_gnt_q <= owner_q;
    end
  end
`else
  assign win_d = ~req_eff[0];
`endif

  assign sel_we    = win_d ? m1_we    : m0_we;
  assign sel_addr  = win_d ? m1_addr  : m0_addr;
  assign sel_wdata = win_d ? m1_wdata : m0_wdata;
  assign cnt_d     = cnt_q + 8'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      gnt_q       <= '0;
      rvalid_q    <= '0;
      err_q       <= '0;
      rdata_q[0]  <= '0;
      rdata_q[1]  <= '0;
      busy_q      <= 1'b0;
    end else begin
      gnt_q    <= '0;
      rvalid_q <= '0;
      err_q    <= '0;
      case (state_q)
        S_IDLE: begin
          if (|req_eff) begin
            owner_q     <= win_d;
            mem_we_q    <= sel_we;
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
            mem_req_q   <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (mem_ack) begin
            mem_req_q      <= 1'b0;
            gnt_q[owner_q] <= 1'b1;
            if (mem_we_q) begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              cnt_q   <= '0;
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // Real data wins over a timeout landing on the same cycle.
          if (mem_rvalid) begin
            rvalid_q[owner_q] <= 1'b1;
            rdata_q[owner_q]  <= mem_rdata;
            busy_q            <= 1'b0;
            state_q           <= S_IDLE;
          end else if (cnt_d == TIMEOUT_CNT) begin
            rvalid_q[owner_q] <= 1'b1;
            err_q[owner_q]    <= 1'b1;
            rdata_q[owner_q]  <= ERR_DATA;
            cnt_q             <= cnt_d;
            busy_q            <= 1'b0;
            state_q           <= S_IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          mem_req_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

  assign m0_gnt    = gnt_q[0];
  assign m0_rvalid = rvalid_q[0];
  assign m0_err    = err_q[0];
  assign m0_rdata  = rdata_q[0];

  assign m1_gnt    = gnt_q[1];
  assign m1_rvalid = rvalid_q[1];
  assign m1_err    = err_q[1];
  assign m1_rdata  = rdata_q[1];

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed self-checking bench for core_mem_arbiter; expectations switch on ARB_RR_EN.
module tb_core_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_req, m0_we, m0_gnt, m0_rvalid, m0_err;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_we, m1_gnt, m1_rvalid, m1_err;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic          mem_req, mem_we, mem_ack, mem_rvalid, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  core_mem_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .m0_req     (m0_req),
    .m0_we      (m0_we),
    .m0_addr    (m0_addr),
    .m0_wdata   (m0_wdata),
    .m0_gnt     (m0_gnt),
    .m0_rvalid  (m0_rvalid),
    .m0_rdata   (m0_rdata),
    .m0_err     (m0_err),
    .m1_req     (m1_req),
    .m1_we      (m1_we),
    .m1_addr    (m1_addr),
    .m1_wdata   (m1_wdata),
    .m1_gnt     (m1_gnt),
    .m1_rvalid  (m1_rvalid),
    .m1_rdata   (m1_rdata),
    .m1_err     (m1_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_m1_quiet(input string tag);
    check_eq({tag, "_m1"}, {61'd0, m1_gnt, m1_rvalid, m1_err}, 64'd0);
  endtask

  int   exp_win [4];
  int   ngnt;
  logic win, last_win;
  logic [DW-1:0] exp_data;

  initial begin
`ifdef ARB_RR_EN
    exp_win = '{0, 1, 0, 1};
`else
    exp_win = '{0, 0, 0, 0};
`endif
    reset = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    mem_ack = 0; mem_rvalid = 0; mem_rdata = '0;

    // Reset state
    #3;
    check_eq("rst_mem", {mem_req, mem_we, mem_addr, mem_wdata}, '0);
    check_eq("rst_m0", {m0_gnt, m0_rvalid, m0_err, m0_rdata}, '0);
    check_eq("rst_m1", {m1_gnt, m1_rvalid, m1_err, m1_rdata}, '0);
    check_eq("rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;

    // Single read, port 0
    m0_req = 1; m0_we = 0; m0_addr = 32'h10;
    step();
    check_eq("rd0_mem_req", mem_req, 1);
    check_eq("rd0_mem_we", mem_we, 0);
    check_eq("rd0_mem_addr", mem_addr, 32'h10);
    check_eq("rd0_busy", busy, 1);
    step();
    check_eq("rd0_hold_req", mem_req, 1);
    check_eq("rd0_no_gnt_yet", m0_gnt, 0);
    mem_ack = 1;
    step();
    check_eq("rd0_gnt", m0_gnt, 1);
    check_eq("rd0_req_drop", mem_req, 0);
    check_m1_quiet("rd0_gnt");
    mem_ack = 0; m0_req = 0;
    step();
    check_eq("rd0_gnt_pulse", m0_gnt, 0);
    check_eq("rd0_wait_busy", busy, 1);
    mem_rvalid = 1; mem_rdata = 32'h00000004;
    step();
    check_eq("rd0_rvalid", m0_rvalid, 1);
    check_eq("rd0_rdata", m0_rdata, 32'h00000004);
    check_eq("rd0_err", m0_err, 0);
    check_eq("rd0_idle", busy, 0);
    check_m1_quiet("rd0_rv");
    mem_rvalid = 0;
    step();
    check_eq("rd0_rvalid_pulse", m0_rvalid, 0);
    $display("[TB] txn rd port0 addr=10 data=%08h", m0_rdata);

    // Write, port 1, ack withheld for 3 cycles
    m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_wdata = 32'h00000008;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("wr1_stable", {mem_req, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 32'h20, 32'h8});
      check_eq("wr1_no_gnt", m1_gnt, 0);
    end
    mem_ack = 1;
    step();
    check_eq("wr1_gnt", m1_gnt, 1);
    check_eq("wr1_m0_gnt", m0_gnt, 0);
    check_eq("wr1_req_drop", mem_req, 0);
    check_eq("wr1_idle", busy, 0);
    mem_ack = 0; m1_req = 0;
    step();
    check_eq("wr1_no_reissue", mem_req, 0);
    check_eq("wr1_no_rvalid", {m0_rvalid, m1_rvalid, m1_gnt}, 0);
    $display("[TB] txn wr port1 addr=20 data=00000008");

    // Contention: both ports read continuously
    m0_req = 1; m0_we = 0; m0_addr = 32'h100;
    m1_req = 1; m1_we = 0; m1_addr = 32'h200;
    ngnt = 0; last_win = 0; exp_data = '0;
    for (int c = 0; c < 15; c++) begin
      step();
      check_eq("cont_dual_gnt", m0_gnt & m1_gnt, 0);
      if (m0_rvalid | m1_rvalid) begin
        check_eq("cont_rv_port", m1_rvalid, last_win);
        check_eq("cont_rdata", last_win ? m1_rdata : m0_rdata, exp_data);
        $display("[TB] txn cont rd port%0d data=%08h", last_win, exp_data);
      end
      if (m0_gnt | m1_gnt) begin
        win = m1_gnt;
        if (ngnt < 4) check_eq("cont_win", win, exp_win[ngnt]);
        last_win = win;
        exp_data = 32'h100 + ngnt;
        ngnt++;
      end
      mem_ack = mem_req; mem_rvalid = m0_gnt | m1_gnt; mem_rdata = exp_data;
    end
    check_eq("cont_enough_gnts", ngnt >= 4, 1);
    m0_req = 0; m1_req = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      mem_ack = mem_req; mem_rvalid = m0_gnt | m1_gnt; mem_rdata = exp_data;
    end
    mem_ack = 0; mem_rvalid = 0;
    step();
    check_eq("cont_idle", busy, 0);

    // Timeout on port 0
    m0_req = 1; m0_we = 0; m0_addr = 32'h30;
    step();
    check_eq("to_issue", mem_req, 1);
    mem_ack = 1;
    step();
    check_eq("to_gnt", m0_gnt, 1);
    mem_ack = 0; m0_req = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      check_eq("to_early", {m0_rvalid, busy}, 2'b01);
    end
    step();
    check_eq("to_rvalid", m0_rvalid, 1);
    check_eq("to_err", m0_err, 1);
    check_eq("to_rdata", m0_rdata, 32'hDEADBEEF);
    check_eq("to_idle", busy, 0);
    check_m1_quiet("to");
    $display("[TB] txn rd port0 addr=30 timeout data=%08h", m0_rdata);
    mem_rvalid = 1; mem_rdata = 32'h00001234;
    step();
    check_eq("to_late_ignored", {m0_rvalid, m0_err, m1_rvalid, busy}, 0);
    mem_rvalid = 0;

    // Async reset while in WAIT
    m0_req = 1; m0_we = 0; m0_addr = 32'h40;
    step();
    mem_ack = 1;
    step();
    check_eq("ar_pre_gnt", {m0_gnt, busy}, 2'b11);
    mem_ack = 0; m0_req = 0;
    #2 reset = 1'b0;
    #1;
    check_eq("ar_busy", busy, 0);
    check_eq("ar_mem", {mem_req, mem_we, mem_addr, mem_wdata}, '0);
    check_eq("ar_m0", {m0_gnt, m0_rvalid, m0_err, m0_rdata}, '0);
    check_eq("ar_m1", {m1_gnt, m1_rvalid, m1_err, m1_rdata}, '0);
    #1 reset = 1'b1;
    m1_req = 1; m1_we = 0; m1_addr = 32'h50;
    step();
    check_eq("ar_m1_issue", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 32'h50});
    mem_ack = 1;
    step();
    check_eq("ar_m1_gnt", {m1_gnt, m0_gnt}, 2'b10);
    mem_ack = 0; m1_req = 0; mem_rvalid = 1; mem_rdata = 32'hCAFE0001;
    step();
    check_eq("ar_m1_rvalid", {m1_rvalid, m1_err, m0_rvalid}, 3'b100);
    check_eq("ar_m1_rdata", m1_rdata, 32'hCAFE0001);
    mem_rvalid = 0;
    $display("[TB] txn rd port1 addr=50 data=%08h", m1_rdata);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/core_mem_arbiter.md
Name: core_mem_arbiter

Overview:
- Shares one single-ported data memory between two requesters: port 0 = core data side (ALUResult/WriteData/MemWrite path), port 1 = external loader/debug master.
- Registered FSM: selects a winner, drives the memory port, holds the request until the memory accepts it, then waits for read data and routes it back to the winner.
- Includes a response timeout so a hung memory cannot wedge the core.

Parameters:
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 16, max cycles to wait for mem_rvalid after read acceptance; must be 2..255
- ERR_DATA, 32'hDEADBEEF, rdata returned on timeout

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- m0_req  in  1  port-0 request; held with fields stable until m0_gnt
- m0_we  in  1  port-0 write (1) / read (0)
- m0_addr  in  AW  port-0 address
- m0_wdata  in  DW  port-0 write data
- m0_gnt  out  1  one-cycle pulse: port-0 request accepted by memory
- m0_rvalid  out  1  one-cycle pulse: port-0 read data valid
- m0_rdata  out  DW  port-0 read data
- m0_err  out  1  pulses with m0_rvalid on timeout
- m1_*  same set for port 1
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_ack  in  1  memory accepts the request this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  DW  read data
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (reset=0, async): FSM=IDLE. All outputs 0: mem_*, m*_gnt, m*_rvalid, m*_rdata, m*_err, busy. Timeout counter=0. Owner=0.
- All outputs are registered.
- IDLE:
  - If any m*_req is high, latch the winner's we/addr/wdata and owner; next cycle: mem_req=1, busy=1, state ISSUE.
  - Both requesting: port 0 wins (fixed priority).
- ISSUE:
  - Hold mem_req and fields stable until a cycle with mem_ack=1.
  - On that edge: mem_req→0; owner's gnt pulses high for exactly the following cycle.
  - Write: state→IDLE.
  - Read: state→WAIT, counter cleared.
- WAIT:
  - Counter increments each cycle.
  - mem_rvalid=1: next cycle owner rvalid=1, rdata=mem_rdata, err=0; state→IDLE.
  - Counter reaches TIMEOUT with no rvalid: next cycle owner rvalid=1, rdata=ERR_DATA, err=1; state→IDLE.
  - A late mem_rvalid arriving in IDLE is ignored (not routed).
- Back-to-back: from IDLE, a new mem_req can follow a completion with one idle cycle minimum. A requester still holding req after its gnt is treated as a new request.
- Non-owner port sees gnt/rvalid/err = 0 throughout.
- mem_ack or mem_rvalid outside ISSUE/WAIT respectively: ignored.
- Reset mid-transaction: immediate return to IDLE with all outputs 0; the in-flight transfer is abandoned.
- Requester deasserting req before gnt: undefined usage. The arbiter still completes the latched transfer.

Optional Feature:
- Macro ARB_RR_EN.
- Defined: round-robin priority. A last-granted bit updates on each gnt; when both ports request in IDLE, the port not last granted wins. After reset, port 0 has priority.
- Undefined: fixed priority, port 0 always wins. No last-granted register is built.

Test Plan:
- Single read, port 0:
  - Stimulus: m0 read addr 0x10; mem_ack 1 cycle after mem_req; mem_rvalid 2 cycles later with 0x00000004.
  - Required: m0_gnt one pulse; m0_rvalid one pulse, m0_rdata=0x00000004, m0_err=0; m1_* stay 0.
- Write, port 1:
  - Stimulus: m1 write addr 0x20, wdata 0x00000008; mem_ack held low 3 cycles.
  - Required: mem_req/mem_we/addr/wdata stable for 3 cycles; m1_gnt pulses after ack; FSM IDLE, no rvalid.
- Contention:
  - Stimulus: m0 and m1 both read every cycle; memory acks immediately and returns rvalid next cycle.
  - Required without ARB_RR_EN: only m0 granted. With ARB_RR_EN: grants alternate 0,1,0,1.
- Timeout:
  - Stimulus: m0 read, mem_ack given, mem_rvalid never asserted.
  - Required: after TIMEOUT=16 cycles, m0_rvalid=1, m0_err=1, m0_rdata=0xDEADBEEF; a later mem_rvalid is ignored.
- Async reset mid-read:
  - Stimulus: drive reset=0 between clock edges while in WAIT.
  - Required: mem_req, busy, and all m*_ outputs go 0 immediately, without a clock edge; a fresh m1 read completes normally after reset=1.
